// File: rtl/uart_rx_param_pkg.sv
// Shared definitions for the MiniUart receiver: FSM state encoding and
// sample-point helpers common to the receive datapath and its FIFO sizing.
package uart_rx_param_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } rx_state_e;

  // Centre sample of a bit; the vote uses HALF-1, HALF and HALF+1.
  function automatic int half_point(input int os);
    return os / 2;
  endfunction

  function automatic int fifo_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// CPU-side view of the receiver: pop/clear strobes in, head entry and status out.
interface uart_rx_param_if
  import uart_rx_param_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
);
  localparam int CNT_W = fifo_cnt_w(FIFO_DEPTH);

  logic                 rd;
  logic                 err_clr;
  logic [DATA_BITS-1:0] d_out;
  logic                 pe;
  logic                 fe;
  logic                 rs;
  logic                 overrun;
  logic [CNT_W-1:0]     count;
  logic                 irq;

  modport master (
    output rd, err_clr,
    input  d_out, pe, fe, rs, overrun, count, irq
  );

  modport slave (
    input  rd, err_clr,
    output d_out, pe, fe, rs, overrun, count, irq
  );
endinterface

// File: rtl/uart_rx_param_rx_fifo.sv
// Show-ahead receive FIFO: the head entry is always visible, reads as zero when empty.
module rx_fifo
  import uart_rx_param_pkg::*;
#(
  parameter int W     = 10,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [W-1:0]               wdata_i,
  input  logic                       rd_i,
  output logic [W-1:0]               rdata_o,
  output logic [fifo_cnt_w(DEPTH)-1:0] count_o,
  output logic                       empty_o,
  output logic                       full_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = fifo_cnt_w(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          pop, wr;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign pop     = rd_i & ~empty_o;
  // A full FIFO still accepts a write when the same cycle frees the head slot.
  assign wr      = push_i & (~full_o | pop);

  always_comb begin
    count_d = count_q;
    unique case ({wr, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr)  wptr_q <= wptr_q + AW'(1);
      if (pop) rptr_q <= rptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = empty_o ? '0 : mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/uart_rx_param.sv
// MiniUart receiver: synchronised, oversampled RxD framing with 3-point majority
// vote, parity/framing checks and a show-ahead character FIFO with overrun flag.
module uart_rx_param
  import uart_rx_param_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en_rx,
  input  logic            rxd,
  uart_rx_param_if.slave  bus
);
  localparam int   CW     = $clog2(OVERSAMPLE);
  localparam int   H      = half_point(OVERSAMPLE);
  localparam int   BW     = 4;
  localparam int   EW     = DATA_BITS + 2;
  localparam int   NW     = fifo_cnt_w(FIFO_DEPTH);
  localparam logic ODD_B  = (PARITY_ODD != 0);

  logic [1:0]           sync_q;
  logic                 rxd_s;
  rx_state_e            state_q;
  logic [CW-1:0]        cnt_q;
  logic [BW-1:0]        bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [1:0]           smp_q;
  logic                 pe_q, fe_q, irq_q, overrun_q, overrun_d;
  logic                 vote, at_mid, at_end, last_stop, fe_w;
  logic                 push_w, push_ok, drop, full, empty;
  logic [EW-1:0]        head;
  logic [NW-1:0]        count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], rxd};
  end
  assign rxd_s = sync_q[1];

  assign vote      = maj3(smp_q[1], smp_q[0], rxd_s);
  assign at_mid    = (cnt_q == CW'(H + 1));
  assign at_end    = (cnt_q == CW'(OVERSAMPLE - 1));
  assign last_stop = (bit_q == BW'(STOP_BITS - 1));
  assign fe_w      = fe_q | ~vote;
  assign push_w    = en_rx & (state_q == ST_STOP) & at_mid & last_stop;
  // When full, a same-cycle rd always pops (full implies non-empty).
  assign drop      = push_w & full & ~bus.rd;
  assign push_ok   = push_w & ~drop;
  assign overrun_d = (overrun_q & ~bus.err_clr) | drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      pe_q    <= 1'b0;
      fe_q    <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      irq_q <= push_ok;
      if (en_rx) begin
        unique case (state_q)
          ST_IDLE: begin
            if (!rxd_s) begin
              state_q <= ST_START;
              cnt_q   <= '0;
            end
          end
          ST_START: begin
            cnt_q <= cnt_q + CW'(1);
            if (at_mid && vote) begin
              state_q <= ST_IDLE;
            end else if (at_end) begin
              cnt_q   <= '0;
              bit_q   <= '0;
              pe_q    <= 1'b0;
              fe_q    <= 1'b0;
              state_q <= ST_DATA;
            end
          end
          ST_DATA: begin
            cnt_q <= cnt_q + CW'(1);
            if (at_end) begin
              cnt_q <= '0;
              if (bit_q == BW'(DATA_BITS - 1)) begin
                bit_q   <= '0;
                state_q <= (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
              end else begin
                bit_q <= bit_q + BW'(1);
              end
            end
          end
          ST_PARITY: begin
            cnt_q <= cnt_q + CW'(1);
            if (at_mid) pe_q <= (^shift_q) ^ vote ^ ODD_B;
            if (at_end) begin
              cnt_q   <= '0;
              state_q <= ST_STOP;
            end
          end
          ST_STOP: begin
            cnt_q <= cnt_q + CW'(1);
            if (at_end) begin
              cnt_q <= '0;
              bit_q <= bit_q + BW'(1);
            end
            if (at_mid) begin
              fe_q <= fe_w;
              if (last_stop) state_q <= fe_w ? ST_WAIT_IDLE : ST_IDLE;
            end
          end
          ST_WAIT_IDLE: begin
            if (rxd_s) state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  // Sample and data shift registers carry no control meaning and need no reset.
  always_ff @(posedge clk) begin
    if (en_rx) begin
      if (cnt_q == CW'(H - 1)) smp_q[1] <= rxd_s;
      if (cnt_q == CW'(H))     smp_q[0] <= rxd_s;
      if (state_q == ST_DATA && at_mid) shift_q <= {vote, shift_q[DATA_BITS-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) overrun_q <= 1'b0;
    else        overrun_q <= overrun_d;
  end

  rx_fifo #(
    .W     (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_w),
    .wdata_i ({shift_q, pe_q, fe_w}),
    .rd_i    (bus.rd),
    .rdata_o (head),
    .count_o (count),
    .empty_o (empty),
    .full_o  (full)
  );

  assign bus.d_out   = head[EW-1:2];
  assign bus.pe      = head[1];
  assign bus.fe      = head[0];
  assign bus.rs      = ~empty;
  assign bus.count   = count;
  assign bus.overrun = overrun_q;
  assign bus.irq     = irq_q;

endmodule
